// File: rtl/swd_pkg.sv
// Shared types and constants for the SWD bit engine.
// The effective bit count maps 0 and anything above 8 onto a full byte.
package swd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } swd_state_e;

  localparam int   SWD_MAX_BITS  = 8;
  localparam logic SWD_DIR_WRITE = 1'b0;
  localparam logic SWD_DIR_READ  = 1'b1;

  function automatic logic [3:0] swd_eff_nbits(input logic [3:0] n);
    if (n == 4'd0 || n > 4'(SWD_MAX_BITS)) begin
      return 4'(SWD_MAX_BITS);
    end
    return n;
  endfunction

endpackage

// File: rtl/swd_phase_div.sv
// SWCLK phase counter: strobes last_cycle on the final clk cycle of each
// DIV-cycle phase and wraps to zero on every phase change.
module swd_phase_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  input  logic en,
  output logic last_cycle
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_reg <= '0;
    end else if (restart || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign last_cycle = en && (cnt_reg == LAST);

endmodule

// File: rtl/swd_bit_engine.sv
// SWD bit engine: serialises up to 8 bits LSB-first on SWDIO (write) or
// samples them from SWDIO (read) while generating SWCLK from clk.
module swd_bit_engine
  import swd_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       dir,
  input  logic [3:0] nbits,
  input  logic [7:0] tx_data,
  input  logic       swdio_i,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       swclk,
  output logic       swdio_o,
  output logic       swdio_oe
);

  swd_state_e state_reg;
  logic [3:0] idx_reg;
  logic [3:0] idx_inc;
  logic [3:0] nbits_reg;
  logic       dir_reg;
  logic [7:0] tx_reg;
  logic [7:0] rx_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       swclk_reg;
  logic       swdio_o_reg;
  logic       swdio_oe_reg;

  logic accept;
  logic phase_last;

  assign accept  = (state_reg == IDLE) && start;
  assign idx_inc = idx_reg + 4'd1;

  swd_phase_div #(
    .DIV(DIV)
  ) u_phase_div (
    .clk       (clk),
    .clr_n     (clr_n),
    .restart   (accept),
    .en        (state_reg != IDLE),
    .last_cycle(phase_last)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg    <= IDLE;
      idx_reg      <= 4'd0;
      nbits_reg    <= 4'd0;
      dir_reg      <= SWD_DIR_WRITE;
      tx_reg       <= 8'h00;
      rx_reg       <= 8'h00;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      swclk_reg    <= 1'b0;
      swdio_o_reg  <= 1'b0;
      swdio_oe_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= LOW;
            dir_reg      <= dir;
            nbits_reg    <= swd_eff_nbits(nbits);
            tx_reg       <= tx_data;
            idx_reg      <= 4'd0;
            busy_reg     <= 1'b1;
            swclk_reg    <= 1'b0;
            swdio_oe_reg <= (dir == SWD_DIR_WRITE);
            swdio_o_reg  <= (dir == SWD_DIR_WRITE) ? tx_data[0] : 1'b0;
            if (dir == SWD_DIR_READ) begin
              rx_reg <= 8'h00;
            end
          end
        end
        LOW: begin
          if (phase_last) begin
            state_reg <= HIGH;
            swclk_reg <= 1'b1;
          end
        end
        HIGH: begin
          if (phase_last) begin
            idx_reg <= idx_inc;
            if (dir_reg == SWD_DIR_READ) begin
              rx_reg[idx_reg[2:0]] <= swdio_i;
            end
            if (idx_inc >= nbits_reg) begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              swclk_reg    <= 1'b0;
              swdio_oe_reg <= 1'b0;
              swdio_o_reg  <= 1'b0;
            end else begin
              // next bit's data is presented from its first LOW cycle
              state_reg   <= LOW;
              swclk_reg   <= 1'b0;
              swdio_o_reg <= (dir_reg == SWD_DIR_WRITE) ? tx_reg[idx_inc[2:0]] : 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign rx_data  = rx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign swclk    = swclk_reg;
  assign swdio_o  = swdio_o_reg;
  assign swdio_oe = swdio_oe_reg;

endmodule

// File: tb/tb_swd_bit_engine.sv
// Bench for swd_bit_engine: one DIV=2 and one DIV=1 instance, checked cycle
// by cycle against a bit/phase model derived from the transfer rules.
module tb_swd_bit_engine;

  logic clk = 1'b0;
  logic clr_n = 1'b0;

  logic [1:0]      start_v, dir_v, sdi_v;
  logic [1:0]      busy_v, done_v, swclk_v, sdo_v, oe_v;
  logic [1:0][3:0] nbits_v;
  logic [1:0][7:0] tx_v, rx_v;

  logic [7:0] rx_exp [2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  swd_bit_engine #(.DIV(2)) u_dut0 (
    .clk(clk), .clr_n(clr_n), .start(start_v[0]), .dir(dir_v[0]),
    .nbits(nbits_v[0]), .tx_data(tx_v[0]), .swdio_i(sdi_v[0]),
    .rx_data(rx_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .swclk(swclk_v[0]), .swdio_o(sdo_v[0]), .swdio_oe(oe_v[0])
  );

  swd_bit_engine #(.DIV(1)) u_dut1 (
    .clk(clk), .clr_n(clr_n), .start(start_v[1]), .dir(dir_v[1]),
    .nbits(nbits_v[1]), .tx_data(tx_v[1]), .swdio_i(sdi_v[1]),
    .rx_data(rx_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .swclk(swclk_v[1]), .swdio_o(sdo_v[1]), .swdio_oe(oe_v[1])
  );

  function automatic int div_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (chain=1)
  // or one idle cycle later (chain=0).
  task automatic do_xfer(input int u, input logic d, input logic [3:0] nb,
                         input logic [7:0] tx, input logic [7:0] rxbits,
                         input int glitch_k, input bit chain, input string name);
    int n, dv, total, rises, b;
    logic hi, prev_clk, exp_o;
    logic [4:0] got, want;
    logic [7:0] mask;
    n     = (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
    dv    = div_of(u);
    total = n * 2 * dv;
    mask  = 8'(((1 << n) - 1));
    start_v[u] = 1'b1; dir_v[u] = d; nbits_v[u] = nb; tx_v[u] = tx;
    @(negedge clk);
    tx_v[u] = 8'($urandom); dir_v[u] = 1'($urandom); nbits_v[u] = 4'($urandom);
    rises = 0; prev_clk = 1'b0;
    for (int k = 0; k < total; k++) begin
      b     = k / (2 * dv);
      hi    = ((k % (2 * dv)) >= dv);
      exp_o = d ? 1'b0 : tx[b];
      start_v[u] = (k == glitch_k);
      if (k == glitch_k) begin
        tx_v[u]  = ~tx;
        dir_v[u] = ~d;
      end
      got  = {busy_v[u], done_v[u], swclk_v[u], oe_v[u], sdo_v[u]};
      want = {1'b1, 1'b0, hi, ~d, exp_o};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s u%0d cycle %0d {busy,done,swclk,oe,o}: got %b want %b", name, u, k, got, want);
      end
      if (swclk_v[u] && !prev_clk) rises++;
      prev_clk = swclk_v[u];
      sdi_v[u] = rxbits[b];
      @(negedge clk);
    end
    start_v[u] = 1'b0;
    got  = {busy_v[u], done_v[u], swclk_v[u], oe_v[u], sdo_v[u]};
    want = 5'b01000;
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s u%0d done_cycle {busy,done,swclk,oe,o}: got %b want %b", name, u, got, want);
    end
    if (d) rx_exp[u] = rxbits & mask;
    tests++;
    if (rx_v[u] !== rx_exp[u]) begin
      fails++;
      $display("FAIL %s u%0d rx_data: got %h want %h", name, u, rx_v[u], rx_exp[u]);
    end
    tests++;
    if (rises != n) begin
      fails++;
      $display("FAIL %s u%0d swclk_rises: got %0d want %0d", name, u, rises, n);
    end
    if (!chain) begin
      @(negedge clk);
      tests++;
      if ({busy_v[u], done_v[u]} !== 2'b00) begin
        fails++;
        $display("FAIL %s u%0d after_done {busy,done}: got %b want 00", name, u, {busy_v[u], done_v[u]});
      end
    end
    $display("[TB] %s u%0d dir=%0d nbits=%0d tx=%h rx=%h", name, u, d, n, tx, rx_v[u]);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      tests++;
      if ({busy_v[u], done_v[u], swclk_v[u], oe_v[u], sdo_v[u], rx_v[u]} !== 13'd0) begin
        fails++;
        $display("FAIL reset u%0d outputs: got %b want 0", u,
                 {busy_v[u], done_v[u], swclk_v[u], oe_v[u], sdo_v[u], rx_v[u]});
      end
    end
    clr_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_write_a5();
    do_xfer(0, 1'b0, 4'd8, 8'hA5, 8'($urandom), -1, 1'b0, "write_a5");
  endtask

  task automatic test_read_div1();
    do_xfer(1, 1'b1, 4'd3, 8'($urandom), 8'hFB, -1, 1'b0, "read_div1");
  endtask

  task automatic test_nbits0();
    do_xfer(0, 1'b0, 4'd0, 8'hFF, 8'h00, -1, 1'b0, "nbits0");
  endtask

  task automatic test_back_to_back();
    do_xfer(0, 1'b0, 4'd8, 8'h01, 8'h00, -1, 1'b1, "b2b_first");
    do_xfer(0, 1'b0, 4'd8, 8'h80, 8'h00, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_ignore_start();
    do_xfer(0, 1'b0, 4'd8, 8'h3C, 8'h00, 10, 1'b0, "ignore_start");
    do_xfer(1, 1'b1, 4'd5, 8'h00, 8'h15, 3, 1'b0, "ignore_start_rd");
  endtask

  task automatic test_reset_mid();
    start_v[0] = 1'b1; dir_v[0] = 1'b0; nbits_v[0] = 4'd8; tx_v[0] = 8'h5A;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (18) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    tests++;
    if ({busy_v[0], done_v[0], swclk_v[0], oe_v[0], sdo_v[0]} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_mid async {busy,done,swclk,oe,o}: got %b want 00000",
               {busy_v[0], done_v[0], swclk_v[0], oe_v[0], sdo_v[0]});
    end
    rx_exp[0] = 8'h00;
    rx_exp[1] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (done_v[0] !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid done_in_reset: got %b want 0", done_v[0]);
      end
    end
    clr_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy_v[0], done_v[0], swclk_v[0]} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid after_release {busy,done,swclk}: got %b want 000",
               {busy_v[0], done_v[0], swclk_v[0]});
    end
    $display("[TB] reset_mid cleared mid-transfer");
    do_xfer(0, 1'b1, 4'd8, 8'h00, 8'hFF, -1, 1'b0, "reset_mid_read");
  endtask

  task automatic test_random();
    int u, gk;
    for (int i = 0; i < 24; i++) begin
      u  = int'($urandom_range(1, 0));
      gk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
      do_xfer(u, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
              gk, (i != 23) && ($urandom_range(1, 0) == 1), "random");
    end
  endtask

  initial begin
    start_v = '0; dir_v = '0; sdi_v = '0;
    nbits_v = '0; tx_v = '0;
    rx_exp[0] = 8'h00;
    rx_exp[1] = 8'h00;
    test_reset();
    test_write_a5();
    test_read_div1();
    test_nbits0();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
